rat_cu_sequencer: RTL and testbench
===================================

// Module: rat_cu_sequencer
// PURPOSE
//  Parametrised instruction-cycle sequencer for the next-generation RAT control unit.
//  Runs the INIT/FETCH/EXEC cycle and stretches EXEC by MEM_WAIT cycles for scratch-memory opcodes.
//  Arbitrates N_IRQ maskable interrupt sources and drives the interrupt-entry cycle strobes.
//  Sits between the opcode/IRQ inputs and the instruction decoder; the decoder qualifies its EXEC outputs with EXEC.
// PARAMETERS
//  N_IRQ     4  number of interrupt sources (1..8); IRQ_ID_W = max(1,$clog2(N_IRQ))
//  MEM_WAIT  0  extra wait cycles appended to EXEC for memory-class opcodes (0..7)
// PORTS
//  CLK           in   1         system clock, rising edge
//  RESET         in   1         synchronous, active-high reset
//  OPCODE_HI_5   in   5         instruction opcode [17:13]
//  OPCODE_LO_2   in   2         instruction opcode [1:0]
//  I_FLAG        in   1         global interrupt enable (I flag)
//  IRQ           in   N_IRQ     level interrupt requests, synchronous to CLK
//  IRQ_MASK      in   N_IRQ     1 = source enabled
//  RST           out  1         PC/SP reset strobe (INIT)
//  PC_INC        out  1         FETCH strobe
//  EXEC          out  1         decoder may issue writes this cycle (first EXEC cycle only)
//  STALL         out  1         high during WAIT cycles
//  PC_LD         out  1         load PC (INTR)
//  PC_MUX_SEL    out  2         2'b10 in INTR, else 2'b00
//  SP_DECR       out  1         push PC (INTR)
//  SCR_WE        out  1         scratch write (INTR)
//  SCR_ADDR_SEL  out  2         2'b11 (SP-1) in INTR, else 2'b00
//  SCR_DATA_SEL  out  1         1 = PC in INTR, else 0
//  I_CLR         out  1         clear I flag (INTR)
//  FLG_SHAD_LD   out  1         save flags to shadow (INTR)
//  IRQ_ACK       out  N_IRQ     one-hot acknowledge of taken source (INTR)
//  IRQ_ID        out  IRQ_ID_W  index of last taken source, registered
//  STATE         out  3         INIT=0 FETCH=1 EXEC=2 WAIT=3 INTR=4
// BEHAVIOUR
//  - RESET high at any rising edge: next state INIT, wait counter 0, IRQ_ID 0. Mid-operation reset aborts
//    any WAIT/INTR immediately; no INTR strobe may follow reset.
//  - All outputs decode from registered state: every strobe is 0 except in the state listed; RST=1 in INIT.
//  - INIT -> FETCH (1 cycle). FETCH -> EXEC (1 cycle).
//  - Memory class {HI,LO}: 0001010,0001011,11100xx,11101xx,0100101,0100110,0010001,0110010.
//  - EXEC: memory class and MEM_WAIT>0 -> WAIT, counter loads MEM_WAIT-1; else end-of-instruction.
//  - WAIT: counter decrements; at 0 -> end-of-instruction. OPCODE must be held stable by the fetch path.
//  - End-of-instruction: pend = IRQ & IRQ_MASK sampled this cycle only; if I_FLAG && |pend -> INTR,
//    else FETCH. Requests raised/dropped in other cycles are ignored (level must be held).
//  - Priority: lowest set index of pend wins; IRQ_ID registered on entry to INTR; IRQ_ACK[IRQ_ID]=1 in INTR.
//  - INTR lasts 1 cycle -> FETCH always (no back-to-back INTR; I_CLR masks further entry).
//  - Latency: non-memory instr 2 cycles; memory instr 2+MEM_WAIT; interrupt entry +1.
//  - IRQ_MASK=0 or I_FLAG=0: pending requests never enter INTR. N_IRQ=1: IRQ_ID width 1, always 0.
//  - Unknown opcodes are non-memory (decoder handles legality).
// TESTING
//  1 RESET=1 two cycles, release: STATE 0 (RST=1) -> 1 (PC_INC=1) -> 2 (EXEC=1) -> 1; all other outputs 0.
//  2 MEM_WAIT=2, opcode 1110000 (LD imm): FETCH,EXEC,WAIT,WAIT,FETCH, STALL=1 for exactly 2 cycles;
//    opcode 0001001 (MOV RR): FETCH,EXEC,FETCH, STALL never high.
//  3 I_FLAG=1, IRQ=4'b1010, MASK=4'b1111 held: after EXEC -> INTR with IRQ_ID=1, IRQ_ACK=0010, PC_LD=1,
//    PC_MUX_SEL=10, SP_DECR=SCR_WE=I_CLR=FLG_SHAD_LD=1, SCR_ADDR_SEL=11; next STATE=FETCH.
//  4 IRQ=4'b0010, MASK=4'b1101 or I_FLAG=0: no INTR over 10 instructions; IRQ pulsed only in FETCH: ignored.
//  5 MEM_WAIT=3, IRQ asserted in first WAIT and held: INTR entered only after last WAIT cycle.
//  6 RESET asserted during WAIT and during INTR: next STATE=INIT, IRQ_ID=0, no further INTR strobes.

Source files
------------

// File: rtl/rat_cu_sequencer_if.sv
// rtl/rat_cu_sequencer_if.sv - opcode/IRQ inputs and cycle strobes of the RAT control-unit sequencer
// Master: fetch/IRQ side that drives opcode, I flag and requests, and consumes the strobes.
// Slave:  the sequencer itself.
// Inputs to the sequencer:
//   opcode_hi_5 / opcode_lo_2  opcode bits [17:13] / [1:0]
//   i_flag                     global interrupt enable
//   irq / irq_mask             level requests and per-source enables
// Outputs of the sequencer:
//   rst, pc_inc, exec, stall   INIT / FETCH / first EXEC / WAIT strobes
//   pc_ld .. flg_shad_ld       interrupt-entry strobes (INTR only)
//   irq_ack / irq_id           one-hot ack in INTR, index of last taken source
//   state                      INIT=0 FETCH=1 EXEC=2 WAIT=3 INTR=4
interface rat_cu_sequencer_if #(
    parameter int N_IRQ    = 4,
    parameter int IRQ_ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
    logic [4:0]          opcode_hi_5;
    logic [1:0]          opcode_lo_2;
    logic                i_flag;
    logic [N_IRQ-1:0]    irq;
    logic [N_IRQ-1:0]    irq_mask;

    logic                rst;
    logic                pc_inc;
    logic                exec;
    logic                stall;
    logic                pc_ld;
    logic [1:0]          pc_mux_sel;
    logic                sp_decr;
    logic                scr_we;
    logic [1:0]          scr_addr_sel;
    logic                scr_data_sel;
    logic                i_clr;
    logic                flg_shad_ld;
    logic [N_IRQ-1:0]    irq_ack;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [2:0]          state;

    modport master (
        output opcode_hi_5, opcode_lo_2, i_flag, irq, irq_mask,
        input  rst, pc_inc, exec, stall, pc_ld, pc_mux_sel, sp_decr, scr_we,
               scr_addr_sel, scr_data_sel, i_clr, flg_shad_ld, irq_ack, irq_id, state
    );

    modport slave (
        input  opcode_hi_5, opcode_lo_2, i_flag, irq, irq_mask,
        output rst, pc_inc, exec, stall, pc_ld, pc_mux_sel, sp_decr, scr_we,
               scr_addr_sel, scr_data_sel, i_clr, flg_shad_ld, irq_ack, irq_id, state
    );
endinterface

// File: rtl/rat_cu_sequencer.sv
// rtl/rat_cu_sequencer.sv - INIT/FETCH/EXEC/WAIT/INTR instruction-cycle sequencer with IRQ arbitration
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  synchronous, active-high reset
//   seq_if   rat_cu_sequencer_if.slave (opcode, I flag, IRQ inputs; cycle strobes, IRQ_ID, STATE)
// Parameters:
//   N_IRQ     number of interrupt sources (1..8)
//   MEM_WAIT  extra EXEC wait cycles for scratch-memory opcodes (0..7)
module rat_cu_sequencer #(
    parameter int N_IRQ    = 4,
    parameter int MEM_WAIT = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    rat_cu_sequencer_if.slave    seq_if
);
    localparam int IRQ_ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam bit HAS_WAIT = (MEM_WAIT > 0);
    // Counter holds "remaining WAIT cycles after this one", so it loads MEM_WAIT-1.
    localparam int          WAIT_LOAD_I = HAS_WAIT ? MEM_WAIT - 1 : 0;
    localparam logic [2:0]  WAIT_LOAD   = WAIT_LOAD_I[2:0];

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            wait_cnt_q, wait_cnt_d;
    logic [IRQ_ID_W-1:0]   irq_id_q, irq_id_d;

    logic [6:0]            opcode;
    logic                  is_mem;
    logic [N_IRQ-1:0]      pend;
    logic [IRQ_ID_W-1:0]   win_id;
    logic                  end_instr;
    logic                  in_intr;

    assign opcode = {seq_if.opcode_hi_5, seq_if.opcode_lo_2};
    assign pend   = seq_if.irq & seq_if.irq_mask;

    // Scratch-memory opcode class; anything else (including illegal codes) is non-memory.
    always_comb begin
        is_mem = 1'b0;
        casez (opcode)
            7'b0001010, 7'b0001011,
            7'b11100??, 7'b11101??,
            7'b0100101, 7'b0100110,
            7'b0010001, 7'b0110010: is_mem = 1'b1;
            default:                is_mem = 1'b0;
        endcase
    end

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                win_id = IRQ_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_INIT;
            wait_cnt_q <= 3'd0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            irq_id_q   <= irq_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        irq_id_d   = irq_id_q;
        end_instr  = 1'b0;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_mem && HAS_WAIT) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    end_instr = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    end_instr = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_INTR:  state_d = ST_FETCH;
            default:  state_d = ST_INIT;
        endcase

        // Requests are only looked at on the last cycle of an instruction.
        if (end_instr) begin
            if (seq_if.i_flag && (|pend)) begin
                state_d  = ST_INTR;
                irq_id_d = win_id;
            end else begin
                state_d  = ST_FETCH;
            end
        end
    end

    assign in_intr = (state_q == ST_INTR);

    assign seq_if.rst          = (state_q == ST_INIT);
    assign seq_if.pc_inc       = (state_q == ST_FETCH);
    assign seq_if.exec         = (state_q == ST_EXEC);
    assign seq_if.stall        = (state_q == ST_WAIT);
    assign seq_if.pc_ld        = in_intr;
    assign seq_if.pc_mux_sel   = in_intr ? 2'b10 : 2'b00;
    assign seq_if.sp_decr      = in_intr;
    assign seq_if.scr_we       = in_intr;
    assign seq_if.scr_addr_sel = in_intr ? 2'b11 : 2'b00;
    assign seq_if.scr_data_sel = in_intr;
    assign seq_if.i_clr        = in_intr;
    assign seq_if.flg_shad_ld  = in_intr;
    assign seq_if.irq_ack      = in_intr ? (N_IRQ'(1) << irq_id_q) : '0;
    assign seq_if.irq_id       = irq_id_q;
    assign seq_if.state        = state_q;
endmodule

// File: tb/tb_rat_cu_sequencer.sv
// tb/tb_rat_cu_sequencer.sv - randomized bench for rat_cu_sequencer, MEM_WAIT=2 and MEM_WAIT=3 instances
module tb_rat_cu_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic [6:0] opc   [2];
    logic       iflag [2];
    logic [3:0] irq   [2];
    logic [3:0] mask  [2];

    logic [17:0] obs_str   [2];
    logic [2:0]  obs_state [2];
    logic [1:0]  obs_id    [2];

    rat_cu_sequencer_if #(.N_IRQ(4)) bus_w2 ();
    rat_cu_sequencer_if #(.N_IRQ(4)) bus_w3 ();

    assign bus_w2.opcode_hi_5 = opc[0][6:2];
    assign bus_w2.opcode_lo_2 = opc[0][1:0];
    assign bus_w2.i_flag      = iflag[0];
    assign bus_w2.irq         = irq[0];
    assign bus_w2.irq_mask    = mask[0];
    assign bus_w3.opcode_hi_5 = opc[1][6:2];
    assign bus_w3.opcode_lo_2 = opc[1][1:0];
    assign bus_w3.i_flag      = iflag[1];
    assign bus_w3.irq         = irq[1];
    assign bus_w3.irq_mask    = mask[1];

    rat_cu_sequencer #(.N_IRQ(4), .MEM_WAIT(2)) dut_w2 (
        .clk_i(clk), .reset_i(rst_v[0]), .seq_if(bus_w2.slave));
    rat_cu_sequencer #(.N_IRQ(4), .MEM_WAIT(3)) dut_w3 (
        .clk_i(clk), .reset_i(rst_v[1]), .seq_if(bus_w3.slave));

    assign obs_str[0] = {bus_w2.rst, bus_w2.pc_inc, bus_w2.exec, bus_w2.stall, bus_w2.pc_ld,
                         bus_w2.pc_mux_sel, bus_w2.sp_decr, bus_w2.scr_we, bus_w2.scr_addr_sel,
                         bus_w2.scr_data_sel, bus_w2.i_clr, bus_w2.flg_shad_ld, bus_w2.irq_ack};
    assign obs_str[1] = {bus_w3.rst, bus_w3.pc_inc, bus_w3.exec, bus_w3.stall, bus_w3.pc_ld,
                         bus_w3.pc_mux_sel, bus_w3.sp_decr, bus_w3.scr_we, bus_w3.scr_addr_sel,
                         bus_w3.scr_data_sel, bus_w3.i_clr, bus_w3.flg_shad_ld, bus_w3.irq_ack};
    assign obs_state[0] = bus_w2.state;
    assign obs_state[1] = bus_w3.state;
    assign obs_id[0]    = bus_w2.irq_id;
    assign obs_id[1]    = bus_w3.irq_id;

    int n_vec = 0;
    int n_err = 0;

    // Reference: position k within the current instruction (0 = fetch, 1 = exec, >=2 = wait),
    // plus flags for the reset cycle and the one-cycle interrupt entry.
    int mw     [2] = '{2, 3};
    bit m_init [2];
    bit m_intr [2];
    int m_k    [2];
    int m_id   [2];

    logic [6:0] mem_list [8] = '{7'b0001010, 7'b0001011, 7'b1110000, 7'b1110100,
                                 7'b0100101, 7'b0100110, 7'b0010001, 7'b0110010};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_mem_ref(input logic [6:0] o);
        if (o[6:2] == 5'b11100 || o[6:2] == 5'b11101) return 1'b1;
        return (o == 7'b0001010) || (o == 7'b0001011) || (o == 7'b0100101) ||
               (o == 7'b0100110) || (o == 7'b0010001) || (o == 7'b0110010);
    endfunction

    function automatic int exp_state(input int d);
        if (m_init[d]) return 0;
        if (m_intr[d]) return 4;
        if (m_k[d] == 0) return 1;
        if (m_k[d] == 1) return 2;
        return 3;
    endfunction

    task automatic model_edge(input int d);
        int nw;
        logic [3:0] pend;
        bit found;
        if (rst_v[d]) begin
            m_init[d] = 1'b1; m_intr[d] = 1'b0; m_k[d] = 0; m_id[d] = 0;
        end else if (m_init[d]) begin
            m_init[d] = 1'b0; m_k[d] = 0;
        end else if (m_intr[d]) begin
            m_intr[d] = 1'b0; m_k[d] = 0;
        end else if (m_k[d] == 0) begin
            m_k[d] = 1;
        end else begin
            nw = is_mem_ref(opc[d]) ? mw[d] : 0;
            if (m_k[d] == 1 + nw) begin
                m_k[d] = 0;
                pend = irq[d] & mask[d];
                if (iflag[d] && pend != 4'd0) begin
                    m_intr[d] = 1'b1;
                    found = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (pend[i] && !found) begin
                            m_id[d] = i;
                            found = 1'b1;
                        end
                    end
                end
            end else begin
                m_k[d] = m_k[d] + 1;
            end
        end
    endtask

    task automatic check_dut(input int d);
        int s;
        bit in_i;
        logic [17:0] e;
        logic [3:0] ack;
        s = exp_state(d);
        in_i = (s == 4);
        ack = in_i ? (4'b0001 << m_id[d]) : 4'b0000;
        e = {s == 0, s == 1, s == 2, s == 3, in_i, in_i ? 2'b10 : 2'b00, in_i, in_i,
             in_i ? 2'b11 : 2'b00, in_i, in_i, in_i, ack};
        check_eq($sformatf("dut%0d state", d), 32'(obs_state[d]), 32'(s));
        check_eq($sformatf("dut%0d strobes", d), 32'(obs_str[d]), 32'(e));
        check_eq($sformatf("dut%0d irq_id", d), 32'(obs_id[d]), 32'(m_id[d]));
    endtask

    function automatic logic [6:0] pick_mem();
        logic [6:0] o;
        o = mem_list[$urandom_range(0, 7)];
        if (o[6:3] == 4'b1110) o[1:0] = 2'($urandom);
        return o;
    endfunction

    // Opcodes only change while in FETCH, so EXEC/WAIT always see a stable opcode.
    task automatic gen(input int d, input int ph, input int cyc);
        int s;
        s = exp_state(d);
        rst_v[d] = 1'b0;
        case (ph)
            0: begin
                rst_v[d] = (cyc < 2);
                opc[d] = 7'b0001001; iflag[d] = 1'b0; irq[d] = 4'b0000; mask[d] = 4'b1111;
            end
            1: begin
                if (s == 1) opc[d] = (cyc % 2 == 1) ? 7'b1110000 : 7'b0001001;
                iflag[d] = 1'b0; irq[d] = 4'b1111; mask[d] = 4'b1111;
            end
            2: begin
                if (s == 1) opc[d] = ($urandom_range(0, 1) == 1) ? pick_mem() : 7'($urandom);
                iflag[d] = 1'b1; irq[d] = 4'b1010; mask[d] = 4'b1111;
            end
            3: begin
                if (s == 1) opc[d] = ($urandom_range(0, 1) == 1) ? pick_mem() : 7'($urandom);
                if (cyc < 60) begin
                    iflag[d] = 1'b1; irq[d] = 4'b0010; mask[d] = 4'b1101;
                end else if (cyc < 120) begin
                    iflag[d] = 1'b0; irq[d] = 4'($urandom); mask[d] = 4'b1111;
                end else begin
                    iflag[d] = 1'b1; mask[d] = 4'b1111;
                    irq[d] = (s == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
                end
            end
            4: begin
                if (s == 1) begin
                    opc[d] = pick_mem();
                    irq[d] = 4'b0000;
                end else if (s == 3 && irq[d] == 4'b0000) begin
                    irq[d] = 4'($urandom_range(1, 15));
                end
                iflag[d] = 1'b1; mask[d] = 4'b1111;
            end
            default: begin
                if (s == 1) opc[d] = ($urandom_range(0, 1) == 1) ? pick_mem() : 7'($urandom);
                iflag[d] = ($urandom_range(0, 3) != 0);
                irq[d]   = 4'($urandom);
                mask[d]  = 4'($urandom);
                if (s == 3 || s == 4) rst_v[d] = ($urandom_range(0, 3) == 0);
                else                  rst_v[d] = ($urandom_range(0, 39) == 0);
            end
        endcase
    endtask

    int ph_len [6] = '{10, 40, 40, 180, 80, 400};

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; opc[d] = 7'd0; iflag[d] = 1'b0; irq[d] = 4'd0; mask[d] = 4'd0;
            m_init[d] = 1'b1; m_intr[d] = 1'b0; m_k[d] = 0; m_id[d] = 0;
        end
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                @(negedge clk);
                gen(0, p, c);
                gen(1, p, c);
                @(posedge clk);
                model_edge(0);
                model_edge(1);
                #1;
                check_dut(0);
                check_dut(1);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
